// File: rtl/lc3b_mem_responder.sv
// lc3b_mem_responder
//   Behavioural memory model that answers an LC-3b style initiator. The
//   initiator presents a byte address and holds mem_read and/or mem_write
//   high until it sees mem_resp. The responder accepts the request in IDLE,
//   waits LATENCY cycles and pulses mem_resp for one cycle.
//
// Handshake: a request is accepted in any IDLE cycle where
//   (mem_read | mem_write) is high. Address, op, mask and data are latched
//   at acceptance, and later changes are ignored. If the request drops while
//   BUSY, the transaction is abandoned with no write and no mem_resp.
//   mem_resp is high exactly LATENCY cycles after the acceptance cycle. The
//   following cycle is IDLE again.
//
// Ports:
//   clk             sole clock
//   rst             synchronous active-high reset
//   mem_address     byte address; word index = mem_address[ADDR_BITS:1]
//   mem_read        read request
//   mem_write       write request (wins if both are high)
//   mem_byte_enable write mask, bit0 = [7:0], bit1 = [15:8]
//   mem_wdata       write data
//   mem_rdata       registered read data, valid in a read RESP cycle, held otherwise
//   mem_resp        registered one-cycle completion pulse
//   proto_err       registered one-cycle pulse: read and write both high at acceptance
//   fsm_state       current FSM state (0 IDLE, 1 BUSY, 2 RESP) for observation
module lc3b_mem_responder #(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] mem_address,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_byte_enable,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  output logic        mem_resp,
  output logic        proto_err,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam int          DEPTH  = 2 ** ADDR_BITS;
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]   idx_q, idx_d;
  logic                   is_wr_q, is_wr_d;
  logic [1:0]             be_q, be_d;
  logic [15:0]            wdata_q, wdata_d;
  logic [15:0]            rdata_q, rdata_d;
  logic                   resp_q, resp_d;
  logic                   perr_q, perr_d;

  logic [15:0]            mem_q [DEPTH];

  logic                   req;
  logic                   unused_addr;

  assign req = mem_read | mem_write;
  // Only the word-index bits are used; the rest alias by design.
  assign unused_addr = ^mem_address;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    is_wr_d = is_wr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    resp_d  = 1'b0;
    perr_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          idx_d   = mem_address[ADDR_BITS:1];
          is_wr_d = mem_write;
          be_d    = mem_byte_enable;
          wdata_d = mem_wdata;
          cnt_d   = LAT_M1;
          perr_d  = mem_read & mem_write;
          if (LAT_M1 == 4'd0) begin
            state_d = S_RESP;
            resp_d  = 1'b1;
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (!req) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q <= 4'd1) begin
          state_d = S_RESP;
          cnt_d   = 4'd0;
          resp_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Read data is captured on entry to RESP so it is registered and valid
    // for the whole RESP cycle; writes leave it untouched.
    if (state_d == S_RESP && state_q != S_RESP && !is_wr_d) begin
      rdata_d = mem_q[idx_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      is_wr_q <= 1'b0;
      be_q    <= 2'b00;
      wdata_q <= 16'h0000;
      rdata_q <= 16'h0000;
      resp_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      is_wr_q <= is_wr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
      perr_q  <= perr_d;
    end
  end

  // Array is not reset. A write commits at the edge ending RESP unless reset
  // is asserted at that same edge, in which case the transaction is dropped.
  always_ff @(posedge clk) begin
    if (!rst && state_q == S_RESP && is_wr_q) begin
      if (be_q[0]) mem_q[idx_q][7:0]  <= wdata_q[7:0];
      if (be_q[1]) mem_q[idx_q][15:8] <= wdata_q[15:8];
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_resp  = resp_q;
  assign proto_err = perr_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Directed bench for lc3b_mem_responder. Two instances share all inputs:
// dut_a uses LATENCY=3 and dut_b uses LATENCY=1. The sel signal chooses
// whose outputs are observed.
module tb_lc3b_mem_responder;

  logic        clk;
  logic        rst;
  logic [15:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_wdata;

  logic [15:0] rdata_a, rdata_b;
  logic        resp_a, resp_b, perr_a, perr_b;
  logic [1:0]  st_a, st_b;

  logic        sel;
  logic [15:0] obs_rdata;
  logic        obs_resp, obs_perr;
  logic [1:0]  obs_state;

  int vectors = 0;
  int errors  = 0;

  lc3b_mem_responder #(.ADDR_BITS(8), .LATENCY(3)) dut_a (
    .clk(clk), .rst(rst), .mem_address(mem_address), .mem_read(mem_read),
    .mem_write(mem_write), .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
    .mem_rdata(rdata_a), .mem_resp(resp_a), .proto_err(perr_a), .fsm_state(st_a)
  );

  lc3b_mem_responder #(.ADDR_BITS(8), .LATENCY(1)) dut_b (
    .clk(clk), .rst(rst), .mem_address(mem_address), .mem_read(mem_read),
    .mem_write(mem_write), .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
    .mem_rdata(rdata_b), .mem_resp(resp_b), .proto_err(perr_b), .fsm_state(st_b)
  );

  assign obs_rdata = sel ? rdata_b : rdata_a;
  assign obs_resp  = sel ? resp_b  : resp_a;
  assign obs_perr  = sel ? perr_b  : perr_a;
  assign obs_state = sel ? st_b    : st_a;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one request and holds it until mem_resp (bounded by 20 cycles).
  // lat = cycles from acceptance edge to the cycle mem_resp is seen (0 = timeout).
  // scramble changes address/data/mask right after acceptance.
  task automatic do_op(input bit rd, input bit wr, input logic [15:0] addr,
                       input logic [1:0] be, input logic [15:0] wd, input bit scramble,
                       output int lat, output int perr_cnt, output int perr_at);
    mem_read        = rd;
    mem_write       = wr;
    mem_address     = addr;
    mem_byte_enable = be;
    mem_wdata       = wd;
    lat      = 0;
    perr_cnt = 0;
    perr_at  = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (scramble && i == 1) begin
        mem_address     = ~addr;
        mem_wdata       = ~wd;
        mem_byte_enable = ~be;
      end
      if (obs_perr) begin
        perr_cnt++;
        perr_at = i;
      end
      if (obs_resp) begin
        lat = i;
        break;
      end
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
    step();
  endtask

  initial begin
    int lat, pc, pa, resp_cnt;

    sel             = 1'b0;
    rst             = 1'b1;
    mem_address     = 16'h0000;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = 2'b00;
    mem_wdata       = 16'h0000;
    step();
    step();
    check("rst_resp",  {15'd0, obs_resp}, 16'h0000);
    check("rst_perr",  {15'd0, obs_perr}, 16'h0000);
    check("rst_rdata", obs_rdata, 16'h0000);
    check("rst_state", {14'd0, obs_state}, 16'h0000);
    rst = 1'b0;
    step();

    // basic write/read with latency 3
    do_op(0, 1, 16'h0010, 2'b11, 16'hBEEF, 0, lat, pc, pa);
    check("wr_beef_lat", 16'(lat), 16'd3);
    check("wr_beef_perr", 16'(pc), 16'd0);
    check("wr_keeps_rdata", obs_rdata, 16'h0000);
    do_op(1, 0, 16'h0010, 2'b00, 16'h0000, 0, lat, pc, pa);
    check("rd_beef_lat", 16'(lat), 16'd3);
    check("rd_beef", obs_rdata, 16'hBEEF);

    // byte masks
    do_op(0, 1, 16'h0020, 2'b11, 16'h1234, 0, lat, pc, pa);
    do_op(0, 1, 16'h0020, 2'b10, 16'hAB00, 0, lat, pc, pa);
    do_op(1, 0, 16'h0020, 2'b00, 16'h0000, 0, lat, pc, pa);
    check("rd_mask_hi", obs_rdata, 16'hAB34);
    do_op(0, 1, 16'h0020, 2'b01, 16'h00CD, 0, lat, pc, pa);
    check("rdata_hold_after_wr", obs_rdata, 16'hAB34);
    do_op(1, 0, 16'h0020, 2'b00, 16'h0000, 0, lat, pc, pa);
    check("rd_mask_lo", obs_rdata, 16'hABCD);

    // mask 00 completes with no change
    do_op(0, 1, 16'h0020, 2'b00, 16'hFFFF, 0, lat, pc, pa);
    check("wr_mask00_lat", 16'(lat), 16'd3);
    do_op(1, 0, 16'h0020, 2'b00, 16'h0000, 0, lat, pc, pa);
    check("rd_mask00", obs_rdata, 16'hABCD);

    // aliasing and ignored bit0
    do_op(0, 1, 16'h0202, 2'b11, 16'h5555, 0, lat, pc, pa);
    do_op(1, 0, 16'h0002, 2'b00, 16'h0000, 0, lat, pc, pa);
    check("rd_alias", obs_rdata, 16'h5555);
    do_op(1, 0, 16'h0010, 2'b00, 16'h0000, 0, lat, pc, pa);
    check("rd_between", obs_rdata, 16'hBEEF);
    do_op(1, 0, 16'h0003, 2'b00, 16'h0000, 0, lat, pc, pa);
    check("rd_bit0", obs_rdata, 16'h5555);

    // inputs changed during BUSY are ignored
    do_op(0, 1, 16'h0050, 2'b11, 16'h4242, 1, lat, pc, pa);
    do_op(1, 0, 16'h0050, 2'b00, 16'h0000, 0, lat, pc, pa);
    check("busy_latched", obs_rdata, 16'h4242);

    // abort: drop write in the cycle after acceptance
    mem_write       = 1'b1;
    mem_address     = 16'h0010;
    mem_byte_enable = 2'b11;
    mem_wdata       = 16'h9999;
    step();
    check("abort_busy_state", {14'd0, obs_state}, 16'h0001);
    mem_write = 1'b0;
    resp_cnt  = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (obs_resp) resp_cnt++;
    end
    check("abort_no_resp", 16'(resp_cnt), 16'd0);
    check("abort_idle", {14'd0, obs_state}, 16'h0000);
    do_op(1, 0, 16'h0010, 2'b00, 16'h0000, 0, lat, pc, pa);
    check("abort_no_write", obs_rdata, 16'hBEEF);

    // reset during BUSY
    do_op(0, 1, 16'h0030, 2'b11, 16'h0000, 0, lat, pc, pa);
    mem_write   = 1'b1;
    mem_address = 16'h0030;
    mem_wdata   = 16'h1111;
    step();
    step();
    rst = 1'b1;
    step();
    rst       = 1'b0;
    mem_write = 1'b0;
    check("rstbusy_rdata", obs_rdata, 16'h0000);
    resp_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (obs_resp) resp_cnt++;
      step();
    end
    check("rstbusy_no_resp", 16'(resp_cnt), 16'd0);
    do_op(1, 0, 16'h0030, 2'b00, 16'h0000, 0, lat, pc, pa);
    check("rstbusy_rd", obs_rdata, 16'h0000);

    // reset during RESP: no write at that edge
    mem_write   = 1'b1;
    mem_address = 16'h0030;
    mem_wdata   = 16'h2222;
    step();
    step();
    step();
    check("rstresp_in_resp", {15'd0, obs_resp}, 16'h0001);
    rst       = 1'b1;
    mem_write = 1'b0;
    step();
    rst = 1'b0;
    check("rstresp_resp_low", {15'd0, obs_resp}, 16'h0000);
    step();
    do_op(1, 0, 16'h0030, 2'b00, 16'h0000, 0, lat, pc, pa);
    check("rstresp_rd", obs_rdata, 16'h0000);

    // read+write together at latency 3
    do_op(1, 1, 16'h0040, 2'b11, 16'h7777, 0, lat, pc, pa);
    check("both_lat", 16'(lat), 16'd3);
    check("both_perr_cnt", 16'(pc), 16'd1);
    check("both_perr_at", 16'(pa), 16'd1);
    do_op(1, 0, 16'h0040, 2'b00, 16'h0000, 0, lat, pc, pa);
    check("both_rd", obs_rdata, 16'h7777);

    // latency 1 instance
    sel = 1'b1;
    do_op(1, 1, 16'h0044, 2'b11, 16'h7777, 0, lat, pc, pa);
    check("l1_both_lat", 16'(lat), 16'd1);
    check("l1_perr_cnt", 16'(pc), 16'd1);
    check("l1_perr_at", 16'(pa), 16'd1);
    do_op(1, 0, 16'h0044, 2'b00, 16'h0000, 0, lat, pc, pa);
    check("l1_rd_lat", 16'(lat), 16'd1);
    check("l1_rd", obs_rdata, 16'h7777);
    do_op(0, 1, 16'h0046, 2'b01, 16'h3C5A, 0, lat, pc, pa);
    do_op(0, 1, 16'h0046, 2'b10, 16'hA5C3, 0, lat, pc, pa);
    do_op(1, 0, 16'h0046, 2'b00, 16'h0000, 0, lat, pc, pa);
    check("l1_rd_merge", obs_rdata, 16'hA55A);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/lc3b_mem_responder.md
LC3B_MEM_RESPONDER -- requirements
Module: lc3b_mem_responder

Interface
REQ-001 Parameter ADDR_BITS, default 8; word-index width; array depth 2**ADDR_BITS 16-bit words.
REQ-002 Parameter LATENCY, default 3; cycles from request acceptance to mem_resp; legal range 1..15.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 mem_address  input  16  byte address from initiator.
REQ-006 mem_read  input  1  read request; held high by initiator until mem_resp seen.
REQ-007 mem_write  input  1  write request; held high by initiator until mem_resp seen.
REQ-008 mem_byte_enable  input  2  write byte mask; bit0 = low byte [7:0], bit1 = high byte [15:8].
REQ-009 mem_wdata  input  16  write data.
REQ-010 mem_rdata  output  16  read data; registered.
REQ-011 mem_resp  output  1  one-cycle completion pulse; registered.
REQ-012 proto_err  output  1  one-cycle pulse; read and write both seen high at acceptance.

Function
REQ-013 FSM states are IDLE, BUSY and RESP; reset state is IDLE.
REQ-014 IDLE: (mem_read | mem_write) high -> accept; latch address index, op, byte_enable and wdata; load counter with LATENCY-1; go to BUSY, or to RESP when LATENCY == 1.
REQ-015 BUSY: decrement counter each cycle; go to RESP when counter reaches 0 -> mem_resp high exactly LATENCY cycles after the acceptance cycle.
REQ-016 BUSY: mem_read and mem_write both low (request dropped) -> abort; return to IDLE; no write; no mem_resp.
REQ-017 Changes to address, data or mask during BUSY are ignored; latched values at acceptance are used.
REQ-018 RESP: mem_resp = 1 for exactly one cycle, then unconditionally IDLE; a new request is accepted no earlier than the cycle after RESP.
REQ-019 Word index = mem_address[ADDR_BITS:1]; mem_address[0] ignored; bits above ADDR_BITS ignored (aliasing wraps modulo depth).
REQ-020 Write: array word is updated at the clock edge ending the RESP cycle; only bytes with enable = 1 change; mask 2'b00 completes with mem_resp and no change.
REQ-021 Read: mem_rdata is valid during the RESP cycle; value = array word at the latched index; full word regardless of mask.
REQ-022 mem_rdata holds its last value outside read RESP cycles; a write does not change mem_rdata.
REQ-023 Read and write both high at acceptance -> treated as write; proto_err = 1 in the acceptance cycle +1 only.
REQ-024 Back-to-back requests: the initiator drops the request after RESP, so IDLE sees no request; if the request stays high, it is re-accepted as a new transaction. The initiator does not do this.

Reset
REQ-025 rst high at a clock edge -> state IDLE; counter 0; mem_resp 0; proto_err 0; mem_rdata 16'h0000.
REQ-026 Reset mid-transaction (BUSY or RESP) -> transaction discarded; no array write occurs at that edge; no mem_resp afterwards.
REQ-027 Array contents are not cleared by reset; contents are undefined until written.

Verification
REQ-028 LATENCY=3: write 16'hBEEF to address 16'h0010, mask 2'b11; then read address 16'h0010 -> mem_resp 3 cycles after each acceptance; mem_rdata = 16'hBEEF.
REQ-029 Word 16'h1234 at address 16'h0020; write 16'hAB00 with mask 2'b10; read back -> 16'hAB34; repeat with mask 2'b01 and data 16'h00CD -> 16'hABCD.
REQ-030 ADDR_BITS=8: write 16'h5555 to address 16'h0202; read address 16'h0002 -> 16'h5555 (alias); read address 16'h0003 -> 16'h5555 (bit0 ignored).
REQ-031 Drop mem_write in the cycle after acceptance -> no mem_resp; a later read of that address returns the prior value.
REQ-032 Assert rst during BUSY of a write to 16'h0030 holding 16'h0000 -> no mem_resp; mem_rdata = 16'h0000; a later read returns 16'h0000.
REQ-033 mem_read and mem_write both high with data 16'h7777 -> one proto_err pulse; write performed; read back -> 16'h7777; LATENCY=1 run shows mem_resp in the cycle after acceptance.
